rom_read_arbiter: RTL and testbench
===================================

# rom_read_arbiter

Shares one ROM macro (1-cycle registered read, CS-gated latch, OE-gated tri-state output) among NUM_REQ read requesters, e.g. weight fetch, bias fetch and instruction fetch in the CNN accelerator. Each requester gets an address channel (valid/ready) and a response channel (valid/ready). The block drives CS/OE/A, tracks which port owns the in-flight read, and sustains one read per cycle under backpressure without an extra data buffer.

## Interface
- ADDR_BITS, 10, ROM address width; must match the ROM instance.
- NUM_REQ, 2, number of requester ports; legal range 2..4.
- Data width is `DATA_BITS from def.v; it is not a parameter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-port read request.
- req_addr  in  NUM_REQ*ADDR_BITS  flattened addresses; port i uses bits [i*ADDR_BITS +: ADDR_BITS].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot; read data is valid for port i.
- rsp_data  out  `DATA_BITS  shared response data, meaningful only while some rsp_valid bit is 1.
- rsp_ready  in  NUM_REQ  per-port response accept.
- rom_CS  out  1  ROM chip select; ROM latches Memory[A] on the edge where this is high.
- rom_OE  out  1  ROM output enable.
- rom_A  out  ADDR_BITS  ROM address.
- rom_DO  in  `DATA_BITS  ROM data output.

## Operation
- State registers:
  - pend (1b): a read is latched in the ROM and not yet consumed.
  - owner (log2 NUM_REQ): the port that issued the pending read.
  - rr_ptr (log2 NUM_REQ): index of the last granted port.
- free = !pend | (rsp_valid[owner] & rsp_ready[owner]).
- Grant:
  - When free, grant the first requesting port, searching round-robin from rr_ptr+1 upward with wrap-around.
  - req_ready is the one-hot grant. It is combinational from req_valid and state, and is all-zero when !free.
- Issue:
  - rom_CS = |grant.
  - rom_A = req_addr of the granted port.
  - When no port is granted, rom_A = 0.
- On the grant edge: pend←1, owner←granted index, rr_ptr←granted index.
- On an edge with consume and no grant: pend←0.
- Response:
  - rom_OE = pend.
  - rsp_valid[i] = pend & (owner==i).
  - rsp_data = rom_DO.
- Backpressure:
  - While the owner holds rsp_ready low, CS stays low, the ROM latch holds, and data is stable.
  - rsp_valid and rsp_data stay constant until accepted.
- Simultaneous consume and new grant in one cycle is legal. The ROM latch updates on the same edge, so there is no bubble.
- rsp_ready of non-owner ports is ignored.
- Requests are never dropped. A requester must hold req_valid and req_addr until req_ready.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rom_CS=0, rom_OE=0, rom_A=0.
  - pend=0, owner=0, rr_ptr=NUM_REQ-1, so port 0 wins first.
- Latency: a request accepted in cycle N gets rsp_valid in cycle N+1 at the earliest.
- Throughput: one read per cycle when the owner's rsp_ready is held high.
- Fairness: a continuously requesting port is granted within NUM_REQ grants.
- Reset asserted mid-read:
  - pend clears immediately (asynchronously).
  - The stale ROM latch contents are never presented, because OE is low.
- Out-of-range rom_A is not checked; the address passes through unchanged.

## Structure
- def.v holds `DATA_BITS (already defined) and a new `ROM_ADDR_BITS default.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req vector, enable (=free), last-grant pointer.
  - Output: one-hot grant and its encoded index.
  - It is combinational; rr_ptr stays in the parent.
- The top holds the pend/owner/rr_ptr registers and the ROM-side muxing.

## Test plan
- Single read: preload Memory[5]=32'hDEADBEEF; port0 requests addr 5 → req_ready[0] in the same cycle; next cycle rsp_valid=2'b01 and rsp_data=32'hDEADBEEF; rom_OE=1 only in that cycle.
- Back-to-back streaming: port1 requests addrs 0..7 continuously with rsp_ready=1 → 8 responses in 8 consecutive cycles, each equal to Memory[k], with no bubbles.
- Arbitration: both ports request continuously from reset → grants alternate 0,1,0,1; each response's rsp_valid bit matches the issuer.
- Backpressure: port0 response pending, rsp_ready[0]=0 for 3 cycles while port1 requests → req_ready=0, rom_CS=0, rsp_data stable for 3 cycles; on accept, port1 is granted in the same cycle.
- Reset mid-operation: drop rst_n while a response is pending → rsp_valid, rom_OE and rom_CS go to 0 immediately; after release, port 0 wins first and returns correct data.

Source files
------------

// File: rtl/rom_read_arbiter_pkg.sv
// Shared constants, types and helpers for the ROM read arbiter.
// Data width is fixed for the accelerator; address width is a parameter.
package rom_read_arbiter_pkg;

   localparam int unsigned DataBits    = 32;
   localparam int unsigned DefAddrBits = 10;
   localparam int unsigned MaxReq      = 4;

   typedef logic [DataBits-1:0] data_t;

   // Round-robin candidate: the port ofs steps past base, wrapping at n.
   function automatic int unsigned rr_wrap(input int unsigned base,
                                           input int unsigned ofs,
                                           input int unsigned n);
      return (base + ofs) % n;
   endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side and ROM-side signals of the arbiter, bundled in one interface.
// The slave modport is the arbiter; the master modport is requesters plus ROM.
interface rom_read_arbiter_if #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned ADDR_BITS = 10
) ();
   import rom_read_arbiter_pkg::*;

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           rsp_valid;
   data_t                        rsp_data;
   logic [NUM_REQ-1:0]           rsp_ready;
   logic                         rom_CS;
   logic                         rom_OE;
   logic [ADDR_BITS-1:0]         rom_A;
   data_t                        rom_DO;

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      input  rsp_ready,
      output rom_CS,
      output rom_OE,
      output rom_A,
      input  rom_DO
   );

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      output rsp_ready,
      input  rom_CS,
      input  rom_OE,
      input  rom_A,
      output rom_DO
   );

endinterface

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from i_last+1 with wrap
// and returns a one-hot grant plus its encoded index.
module rr_arbiter
   import rom_read_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IdxBits = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   input  logic [IdxBits-1:0] i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IdxBits-1:0] o_idx
);

   always_comb begin
      int unsigned w_cand;
      logic        w_found;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      // k == NUM_REQ revisits i_last itself, so a lone requester is never starved.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_cand = rr_wrap(32'(i_last), k, NUM_REQ);
         if (i_en && !w_found && i_req[w_cand[IdxBits-1:0]]) begin
            o_grant[w_cand[IdxBits-1:0]] = 1'b1;
            o_idx                        = w_cand[IdxBits-1:0];
            w_found                      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-read ROM among NUM_REQ requesters; tracks the owner of
// the read latched in the ROM so consume and re-issue can share one edge.
module rom_read_arbiter
   import rom_read_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DefAddrBits,
   parameter int unsigned NUM_REQ   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   rom_read_arbiter_if.slave  bus
);

   localparam int unsigned IdxBits = $clog2(NUM_REQ);

   logic               r_pend;
   logic [IdxBits-1:0] r_owner;
   logic [IdxBits-1:0] r_rr_ptr;

   logic               w_consume;
   logic               w_free;
   logic [NUM_REQ-1:0] w_grant;
   logic [IdxBits-1:0] w_grant_idx;

   assign w_consume = r_pend & bus.rsp_ready[r_owner];
   // Gated by rst_n so no grant or chip select escapes while reset is held.
   assign w_free    = rst_n & (~r_pend | w_consume);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IdxBits (IdxBits)
   ) u_rr_arbiter (
      .i_req   (bus.req_valid),
      .i_en    (w_free),
      .i_last  (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx)
   );

   assign bus.req_ready = w_grant;
   assign bus.rom_CS    = |w_grant;
   assign bus.rom_OE    = r_pend;
   assign bus.rsp_data  = bus.rom_DO;

   always_comb begin
      bus.rom_A     = '0;
      bus.rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            bus.rom_A = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
         end
      end
      if (r_pend) begin
         bus.rsp_valid[r_owner] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend   <= 1'b0;
         r_owner  <= '0;
         r_rr_ptr <= IdxBits'(NUM_REQ - 1);
      end else if (|w_grant) begin
         r_pend   <= 1'b1;
         r_owner  <= w_grant_idx;
         r_rr_ptr <= w_grant_idx;
      end else if (w_consume) begin
         r_pend   <= 1'b0;
      end
   end

   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_grant));
   a_no_grant_busy : assert property (@(posedge clk) disable iff (!rst_n)
                                      (r_pend && !w_consume) |-> (w_grant == '0));

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural ROM and a scoreboard
// filled on request acceptance and drained by an independent response monitor.
module tb_rom_read_arbiter;
   import rom_read_arbiter_pkg::*;

   localparam int unsigned NReq  = 2;
   localparam int unsigned ABits = 10;

   typedef struct packed {
      logic [0:0] port;
      data_t      data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rom_read_arbiter_if #(.NUM_REQ(NReq), .ADDR_BITS(ABits)) bus ();

   rom_read_arbiter #(
      .ADDR_BITS (ABits),
      .NUM_REQ   (NReq)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   data_t mem [1024];
   data_t rom_latch;
   always @(posedge clk) if (bus.rom_CS) rom_latch <= mem[bus.rom_A];
   assign bus.rom_DO = bus.rom_OE ? rom_latch : '0;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_rsp    = 0;

   function automatic data_t rom_val(input logic [ABits-1:0] a);
      if (a == 10'd5) return 32'hDEADBEEF;
      return {8'h5A ^ a[7:0], ~a[7:0], 6'h00, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int port, input logic [ABits-1:0] a);
      bus.req_addr[port*ABits +: ABits] = a;
   endtask

   // Push the expected response for every accepted request.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NReq; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               exp_t e;
               e.port = 1'(i);
               e.data = rom_val(bus.req_addr[i*ABits +: ABits]);
               exp_q.push_back(e);
            end
         end
      end
   end

   // Pop and compare on every response handshake.
   always @(negedge clk) begin
      if (rst_n && |(bus.rsp_valid & bus.rsp_ready)) begin
         exp_t       e;
         logic [1:0] oh;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got rsp_valid %b expected none", bus.rsp_valid);
         end else begin
            e  = exp_q.pop_front();
            oh = 2'b01 << e.port;
            n_rsp++;
            chk("rsp_port", 64'(bus.rsp_valid), 64'(oh));
            chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a0;
      int a1;
      for (int k = 0; k < 1024; k++) mem[k] = rom_val(10'(k));
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.rsp_ready = 2'b11;

      // Reset state, with a request held to show grants are blocked.
      tick();
      tick();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_cs", 64'(bus.rom_CS), 64'd0);
      chk("rst_oe", 64'(bus.rom_OE), 64'd0);
      chk("rst_a", 64'(bus.rom_A), 64'd0);
      bus.req_valid = 2'b01;
      #1;
      chk("rst_gated_cs", 64'(bus.rom_CS), 64'd0);
      bus.req_valid = '0;
      tick();
      rst_n = 1'b1;

      // Single read.
      set_addr(0, 10'd5);
      bus.req_valid = 2'b01;
      #1;
      chk("single_grant", 64'(bus.req_ready), 64'b01);
      chk("single_cs", 64'(bus.rom_CS), 64'd1);
      chk("single_a", 64'(bus.rom_A), 64'd5);
      chk("single_oe_pre", 64'(bus.rom_OE), 64'd0);
      tick();
      bus.req_valid = '0;
      #1;
      chk("single_valid", 64'(bus.rsp_valid), 64'b01);
      chk("single_data", 64'(bus.rsp_data), 64'hDEADBEEF);
      chk("single_oe", 64'(bus.rom_OE), 64'd1);
      tick();
      chk("single_done_valid", 64'(bus.rsp_valid), 64'd0);
      chk("single_done_oe", 64'(bus.rom_OE), 64'd0);

      // Port 1 streams addresses 0..7 with no bubbles.
      for (int k = 0; k < 8; k++) begin
         set_addr(1, 10'(k));
         bus.req_valid = 2'b10;
         #1;
         chk("stream_grant", 64'(bus.req_ready), 64'b10);
         if (k > 0) chk("stream_nobubble", 64'(bus.rsp_valid), 64'b10);
         tick();
      end
      bus.req_valid = '0;
      #1;
      chk("stream_last", 64'(bus.rsp_valid), 64'b10);
      tick();

      // Both ports request; last grant was port 1, so port 0 leads.
      a0 = 100;
      a1 = 200;
      bus.req_valid = 2'b11;
      for (int j = 0; j < 4; j++) begin
         set_addr(0, 10'(a0));
         set_addr(1, 10'(a1));
         #1;
         chk("arb_grant", 64'(bus.req_ready), (j % 2 == 0) ? 64'b01 : 64'b10);
         if (j % 2 == 0) a0++;
         else a1++;
         tick();
      end
      bus.req_valid = '0;
      tick();

      // Backpressure on port 0 while port 1 waits; non-owner ready is ignored.
      bus.rsp_ready = 2'b10;
      set_addr(0, 10'd20);
      bus.req_valid = 2'b01;
      #1;
      chk("bp_grant0", 64'(bus.req_ready), 64'b01);
      tick();
      set_addr(1, 10'd30);
      bus.req_valid = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
         chk("bp_cs", 64'(bus.rom_CS), 64'd0);
         chk("bp_valid", 64'(bus.rsp_valid), 64'b01);
         chk("bp_data", 64'(bus.rsp_data), 64'(rom_val(10'd20)));
         tick();
      end
      bus.rsp_ready = 2'b11;
      #1;
      chk("bp_accept_grant", 64'(bus.req_ready), 64'b10);
      chk("bp_accept_cs", 64'(bus.rom_CS), 64'd1);
      chk("bp_accept_a", 64'(bus.rom_A), 64'd30);
      tick();
      bus.req_valid = '0;
      #1;
      chk("bp_next_valid", 64'(bus.rsp_valid), 64'b10);
      chk("bp_next_data", 64'(bus.rsp_data), 64'(rom_val(10'd30)));
      tick();

      // Reset while a response is pending.
      set_addr(0, 10'd7);
      bus.req_valid = 2'b01;
      tick();
      set_addr(0, 10'd8);
      bus.rsp_ready = 2'b00;
      #1;
      chk("mid_pending", 64'(bus.rsp_valid), 64'b01);
      chk("mid_oe", 64'(bus.rom_OE), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mid_rst_oe", 64'(bus.rom_OE), 64'd0);
      chk("mid_rst_cs", 64'(bus.rom_CS), 64'd0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      bus.rsp_ready = 2'b11;
      set_addr(0, 10'd9);
      set_addr(1, 10'd50);
      bus.req_valid = 2'b11;
      #1;
      chk("post_rst_grant", 64'(bus.req_ready), 64'b01);
      tick();
      bus.req_valid = 2'b10;
      #1;
      chk("post_rst_valid", 64'(bus.rsp_valid), 64'b01);
      chk("post_rst_data", 64'(bus.rsp_data), 64'(rom_val(10'd9)));
      chk("post_rst_grant1", 64'(bus.req_ready), 64'b10);
      tick();
      bus.req_valid = '0;
      #1;
      chk("post_rst_valid1", 64'(bus.rsp_valid), 64'b10);
      tick();
      tick();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("rsp_count", 64'(n_rsp), 64'd17);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
